// File: rtl/spi_flash_responder.sv
// SPI mode-0 target that impersonates a serial flash: READ streams bytes from a
// backing memory, WAKE and unknown opcodes are swallowed without a response.
module spi_flash_responder #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [7:0]  WAKE_CMD   = 8'hAB
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_cs,
  input  logic                  spi_sclk,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  state_t      state, state_next;
  logic        cs_meta, cs_sync, cs_prev;
  logic        sclk_meta, sclk_sync, sclk_prev;
  logic        mosi_meta, mosi_sync;
  logic        rise, fall, cs_fall;
  logic [4:0]  bit_cnt;
  logic [22:0] shift_reg;
  logic [23:0] addr_cur, addr_in, addr_next;
  logic [7:0]  opcode, byte_buf, tx_shift;
  logic        rd_q;

  assign rise      = sclk_sync & ~sclk_prev;
  assign fall      = ~sclk_sync & sclk_prev;
  // Sync flops reset low, so a cs held low through reset does not look like a new frame.
  assign cs_fall   = cs_prev & ~cs_sync;
  assign opcode    = {shift_reg[6:0], mosi_sync};
  assign addr_in   = {shift_reg, mosi_sync};
  assign addr_next = addr_cur + 24'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_meta   <= 1'b0;
      cs_sync   <= 1'b0;
      cs_prev   <= 1'b0;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      cs_meta   <= spi_cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      sclk_meta <= spi_sclk;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      mosi_meta <= spi_mosi;
      mosi_sync <= mosi_meta;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cs_fall) state_next = CMD;
      CMD: begin
        if (rise && bit_cnt == 5'd7) begin
          if (opcode == READ_CMD)      state_next = ADDR;
          else if (opcode == WAKE_CMD) state_next = IGNORE;
          else                         state_next = IGNORE;
        end
      end
      ADDR: if (rise && bit_cnt == 5'd23) state_next = DATA;
      default: state_next = state;
    endcase
    // Deselect wins over everything, whatever bit we were in the middle of.
    if (state != IDLE && cs_sync) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      addr_cur  <= '0;
      byte_buf  <= '0;
      tx_shift  <= '0;
      rd_q      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      spi_miso  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      rd_q   <= mem_rd;
      busy   <= ~cs_sync;
      if (rd_q) byte_buf <= mem_rdata;

      if (state_next != state)
        bit_cnt <= '0;
      else if (rise && (state == CMD || state == ADDR || state == DATA))
        bit_cnt <= (state == DATA && bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;

      if (state == IDLE && cs_fall)
        shift_reg <= '0;
      else if (rise && (state == CMD || state == ADDR))
        shift_reg <= addr_in[22:0];

      if (state == ADDR && state_next == DATA) begin
        addr_cur <= addr_in;
        mem_addr <= addr_in[ADDR_WIDTH-1:0];
        mem_rd   <= 1'b1;
      end else if (state == DATA && state_next == DATA && rise && bit_cnt == 5'd7) begin
        // Prefetch the next byte; it lands in byte_buf well before the next fall.
        addr_cur <= addr_next;
        mem_addr <= addr_next[ADDR_WIDTH-1:0];
        mem_rd   <= 1'b1;
      end

      if (state_next != DATA) begin
        spi_miso <= 1'b0;
        tx_shift <= '0;
      end else if (state == DATA && fall) begin
        if (bit_cnt == 5'd0) {spi_miso, tx_shift} <= {byte_buf, 1'b0};
        else                 {spi_miso, tx_shift} <= {tx_shift, 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomised bench for spi_flash_responder: an SPI initiator driver, a flat
// memory model, and per-scenario checks against bytes predicted from the memory.
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] rd_log[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          miso_high_cnt = 0;

  spi_flash_responder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_cs    (spi_cs),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory answers one clock after the strobe; junk otherwise so late capture shows up.
  always @(posedge clk) begin
    if (mem_rd) begin
      rd_log.push_back(mem_addr);
      mem_rdata <= mem[mem_addr];
    end else begin
      mem_rdata <= 8'($urandom);
    end
    if (spi_miso) miso_high_cnt <= miso_high_cnt + 1;
  end

  task automatic spi_bits(input int n, input logic [7:0] tx, output logic [7:0] rx);
    int h;
    rx = '0;
    for (int i = 7; i > 7 - n; i--) begin
      h = $urandom_range(4, 7);
      spi_mosi = tx[i];
      repeat (h) @(negedge clk);
      spi_sclk = 1'b1;
      rx[i] = spi_miso;
      repeat (h) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic cs_end();
    spi_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_read_header(input logic [23:0] addr);
    logic [7:0] d;
    logic [23:0] a;
    a = addr;
    spi_bits(8, 8'h03, d);
    spi_bits(8, a[23:16], d);
    spi_bits(8, a[15:8], d);
    spi_bits(8, a[7:0], d);
  endtask

  task automatic do_read(input logic [23:0] addr, input int n);
    logic [7:0] d;
    rx_q.delete();
    cs_begin();
    send_read_header(addr);
    for (int k = 0; k < n; k++) begin
      spi_bits(8, 8'h00, d);
      rx_q.push_back(d);
    end
    cs_end();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    spi_cs = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) spi_sclk = ~spi_sclk;
      spi_mosi = 1'($urandom);
      @(negedge clk);
      checks++;
      if ({spi_miso, mem_rd, mem_addr, busy} !== 19'd0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: miso=%b rd=%b addr=%h busy=%b, required all 0",
                 i, spi_miso, mem_rd, mem_addr, busy);
      end
    end
    spi_cs = 1'b1;
    spi_sclk = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: busy=%b miso=%b, required 0 0", busy, spi_miso);
    end
  endtask

  task automatic test_single_read();
    logic [7:0] d;
    int base;
    mem[16'h0010] = 8'hA5;
    mem[16'h0011] = 8'h3C;
    base = rd_log.size();
    cs_begin();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: got %b, required 1", busy);
    end
    send_read_header(24'h000010);
    checks++;
    if (rd_log.size() != base + 1 || rd_log[base] !== 16'h0010) begin
      errors++;
      $display("FAIL single_rd: %0d reads, first addr %h, required 1 read at 0010",
               rd_log.size() - base, (rd_log.size() > base) ? rd_log[base] : 16'hxxxx);
    end
    spi_bits(8, 8'h00, d);
    checks++;
    if (d !== 8'hA5) begin
      errors++;
      $display("FAIL single_data: got %h, required a5", d);
    end
    cs_end();
    checks++;
    if (rd_log.size() != base + 2 || rd_log[base+1] !== 16'h0011) begin
      errors++;
      $display("FAIL single_prefetch: %0d reads total, required 2 with second at 0011",
               rd_log.size() - base);
    end
    checks++;
    if (busy !== 1'b0 || spi_miso !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b miso=%b, required 0 0", busy, spi_miso);
    end
  endtask

  task automatic test_streaming();
    logic [23:0] a;
    int base;
    for (int i = 0; i < 5; i++) begin
      a = 24'h00FFFE + 24'(i);
      mem[a[15:0]] = 8'h40 + 8'(i);
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      a = 24'h00FFFE + 24'(i);
      exp_q.push_back(mem[a[15:0]]);
    end
    base = rd_log.size();
    do_read(24'h00FFFE, 4);
    for (int i = 0; i < 4; i++) begin
      a = 24'h00FFFE + 24'(i);
      checks++;
      if (rx_q[i] !== exp_q[i] || rd_log[base+i] !== a[15:0]) begin
        errors++;
        $display("FAIL stream_byte%0d: data %h addr %h, required data %h addr %h",
                 i, rx_q[i], rd_log[base+i], exp_q[i], a[15:0]);
      end
    end
    checks++;
    if (rd_log.size() != base + 5) begin
      errors++;
      $display("FAIL stream_rd_count: got %0d, required 5", rd_log.size() - base);
    end
  endtask

  task automatic test_wake_then_read();
    logic [7:0] d;
    int base, m0;
    base = rd_log.size();
    m0 = miso_high_cnt;
    cs_begin();
    spi_bits(8, 8'hAB, d);
    spi_bits(8, 8'h55, d);
    cs_end();
    checks++;
    if (rd_log.size() != base || miso_high_cnt != m0) begin
      errors++;
      $display("FAIL wake_silent: reads=%0d miso_high_cycles=%0d, required 0 0",
               rd_log.size() - base, miso_high_cnt - m0);
    end
    mem[16'h0000] = 8'($urandom);
    do_read(24'h000000, 1);
    checks++;
    if (rx_q[0] !== mem[16'h0000] || rd_log[base] !== 16'h0000) begin
      errors++;
      $display("FAIL wake_read: data %h addr %h, required data %h addr 0000",
               rx_q[0], rd_log[base], mem[16'h0000]);
    end
  endtask

  task automatic test_unknown_opcode();
    logic [7:0] d;
    logic [23:0] a;
    int base, m0;
    base = rd_log.size();
    m0 = miso_high_cnt;
    cs_begin();
    spi_bits(8, 8'h9F, d);
    for (int i = 0; i < 5; i++) spi_bits(8, 8'($urandom), d);
    checks++;
    if (rd_log.size() != base || miso_high_cnt != m0) begin
      errors++;
      $display("FAIL unknown_silent: reads=%0d miso_high_cycles=%0d, required 0 0",
               rd_log.size() - base, miso_high_cnt - m0);
    end
    cs_end();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL unknown_busy: got %b, required 0", busy);
    end
    a = 24'($urandom);
    do_read(a, 1);
    checks++;
    if (rx_q[0] !== mem[a[15:0]]) begin
      errors++;
      $display("FAIL unknown_recover: got %h, required %h", rx_q[0], mem[a[15:0]]);
    end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    logic [23:0] a;
    int base;
    a = 24'($urandom);
    mem[a[15:0]] = 8'hFF;
    a = a + 24'd1;
    mem[a[15:0]] = 8'hFF;
    a = a - 24'd1;
    cs_begin();
    send_read_header(a);
    spi_bits(8, 8'h00, d);
    checks++;
    if (d !== 8'hFF) begin
      errors++;
      $display("FAIL abort_first: got %h, required ff", d);
    end
    spi_bits(3, 8'h00, d);
    spi_cs = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (spi_miso !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: miso=%b busy=%b, required 0 0", spi_miso, busy);
    end
    repeat (4) @(negedge clk);
    mem[16'h0020] = 8'($urandom);
    mem[16'h0021] = 8'($urandom);
    base = rd_log.size();
    do_read(24'h000020, 2);
    checks++;
    if (rx_q[0] !== mem[16'h0020] || rx_q[1] !== mem[16'h0021] || rd_log[base] !== 16'h0020) begin
      errors++;
      $display("FAIL abort_new_read: got %h %h addr %h, required %h %h addr 0020",
               rx_q[0], rx_q[1], rd_log[base], mem[16'h0020], mem[16'h0021]);
    end
  endtask

  task automatic test_random_reads();
    logic [23:0] a, ai;
    int n, base;
    for (int t = 0; t < 6; t++) begin
      a = (t == 0) ? 24'hFFFFFF : 24'($urandom);
      n = $urandom_range(1, 4);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        ai = a + 24'(i);
        exp_q.push_back(mem[ai[15:0]]);
      end
      base = rd_log.size();
      do_read(a, n);
      for (int i = 0; i < n; i++) begin
        ai = a + 24'(i);
        checks++;
        if (rx_q[i] !== exp_q[i] || rd_log[base+i] !== ai[15:0]) begin
          errors++;
          $display("FAIL random_t%0d_b%0d: data %h addr %h, required data %h addr %h",
                   t, i, rx_q[i], rd_log[base+i], exp_q[i], ai[15:0]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
    test_single_read();
    test_streaming();
    test_wake_then_read();
    test_unknown_opcode();
    test_abort();
    test_random_reads();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
